asm_randomizer: RTL
===================

// Module: asm_randomizer
// PURPOSE
// - Stage directly downstream of byte_interleaver.
// - Prepends an attached sync marker (ASM) to every interleaved frame.
// - XORs frame bytes with the CCSDS pseudo-randomizer sequence (h(x)=x^8+x^7+x^5+x^3+1) when enabled.
// - Feeds the TX framer/serializer as a byte stream with sop/last/is_parity/is_asm sidebands.
// PARAMETERS
// FRAME_BYTES  interleaver_pkg::CODEWORD_BYTES  payload bytes per frame (interleaved block)
// ASM_LEN      4                                sync marker length in bytes (1..8)
// ASM_WORD     64'h1ACFFC1D                     marker, right-aligned; emitted MSB-first
// LFSR_SEED    8'hFF                            randomizer seed, reloaded at every frame start
// PORTS
// clk               in   1   clock
// rst_n             in   1   reset; asynchronous, active-low
// rand_en           in   1   randomizer enable; sampled when a frame starts (sop accepted in IDLE)
// s_axis_valid      in   1   input byte valid (from interleaver)
// s_axis_ready      out  1   input byte accepted when valid&ready
// s_axis_data       in   8   interleaved byte
// s_axis_last       in   1   last byte of frame
// s_axis_sop        in   1   first byte of frame
// s_axis_is_parity  in   1   byte is RS parity
// m_axis_valid      out  1   output byte valid
// m_axis_ready      in   1   downstream ready
// m_axis_data       out  8   ASM or (randomized) payload byte
// m_axis_last       out  1   last payload byte of frame
// m_axis_sop        out  1   first ASM byte of frame
// m_axis_is_parity  out  1   passthrough of is_parity (0 on ASM bytes)
// m_axis_is_asm     out  1   byte is a sync-marker byte
// frame_err         out  1   one-cycle pulse on framing violation
// frame_count       out  16  frames completed (last emitted); wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: all m_axis_* = 0, s_axis_ready = 0, frame_err = 0, frame_count = 0, state = IDLE, LFSR = LFSR_SEED.
// - Output: single register stage; slot free = !m_axis_valid | m_axis_ready.
//   - m_axis_* held stable while valid & !ready.
//   - Payload latency: 1 cycle from input handshake to m_axis_valid. No bubbles when ready is held high.
// - FSM IDLE:
//   - s_axis_ready = 1.
//   - valid & !sop: byte consumed and dropped; frame_err pulses.
//   - valid & sop: byte NOT consumed; latch rand_en; load LFSR_SEED; go to ASM with asm_idx = 0.
// - FSM ASM:
//   - s_axis_ready = 0.
//   - Each free slot loads ASM byte asm_idx (MSB-first); is_asm = 1; sop = (asm_idx == 0).
//   - After ASM_LEN bytes, go to DATA with byte_cnt = 0.
// - FSM DATA:
//   - s_axis_ready = slot free.
//   - On handshake: out = data ^ (rand_en_latched ? lfsr_byte : 0).
//   - LFSR advances 8 bits per accepted byte; first lfsr_byte = 8'hFF.
//   - is_parity passes through; byte_cnt++.
// - Frame end: first of s_axis_last or byte_cnt == FRAME_BYTES-1.
//   - That byte is emitted with m_axis_last = 1; frame_count++; return to IDLE.
//   - Mismatch between the two end conditions pulses frame_err; the frame is still closed on that byte.
// - sop seen in DATA with byte_cnt != 0: frame_err pulses; byte treated as payload (no resync).
// - Simultaneous err sources: a single pulse.
// - Reset mid-frame: immediate return to IDLE; any held output byte is discarded.
// - LFSR: 8-bit Fibonacci, taps 8,7,5,3; bit order MSB-first within the byte.
// TESTING
// - Frame of FRAME_BYTES zeros, rand_en=1, ready=1 -> 1A CF FC 1D FF 48 0E C0 9A ...; sop on byte 0 only; last on final byte; frame_count=1.
// - Same frame with rand_en=0 -> ASM then FRAME_BYTES x 00; is_asm=1 on first 4 bytes only; is_parity matches input.
// - 500 back-to-back frames, random valid/ready (ready low about 1/8) -> data matches golden model; frame_count=500; frame_err never asserted.
// - s_axis_last asserted at byte_cnt=10 -> frame closes on byte 10 with last=1; frame_err pulses once; next sop gets a fresh ASM and LFSR=FF.
// - Three non-sop bytes in IDLE -> all dropped; 3 frame_err pulses; no m_axis_valid.
// - rst_n low while in ASM (asm_idx=2) -> outputs 0 asynchronously; next frame restarts at 1A with sop=1.

Source files
------------

// File: rtl/asm_randomizer.sv
// rtl/asm_randomizer.sv - sync-marker insertion and CCSDS randomization of interleaved frames
//
// Sits between byte_interleaver and the TX framer. Each frame is preceded by
// ASM_LEN marker bytes (MSB-first from ASM_WORD). Payload bytes are optionally
// XORed with the CCSDS pseudo-random sequence h(x)=x^8+x^7+x^5+x^3+1, restarted
// from LFSR_SEED at every frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rand_en             randomizer enable, captured when a frame starts
//   s_axis_*            interleaved byte stream in (valid/ready/data/last/sop/is_parity)
//   m_axis_*            byte stream out (valid/ready/data/last/sop/is_parity/is_asm)
//   frame_err           one-cycle pulse on a framing violation
//   frame_count         frames completed, wraps at 16 bits

module asm_randomizer #(
    parameter int          FRAME_BYTES = 255,
    parameter int          ASM_LEN     = 4,
    parameter logic [63:0] ASM_WORD    = 64'h1ACFFC1D,
    parameter logic [7:0]  LFSR_SEED   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rand_en,
    input  logic        s_axis_valid,
    output logic        s_axis_ready,
    input  logic [7:0]  s_axis_data,
    input  logic        s_axis_last,
    input  logic        s_axis_sop,
    input  logic        s_axis_is_parity,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic [7:0]  m_axis_data,
    output logic        m_axis_last,
    output logic        m_axis_sop,
    output logic        m_axis_is_parity,
    output logic        m_axis_is_asm,
    output logic        frame_err,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASM,
        ST_DATA
    } state_t;

    // Marker left-aligned in 64 bits so byte asm_idx is always the top byte
    // after shifting left by 8*asm_idx.
    localparam logic [63:0] ASM_ALIGNED  = ASM_WORD << (8 * (8 - ASM_LEN));
    localparam logic [2:0]  ASM_LAST_IDX = 3'(ASM_LEN - 1);
    localparam logic [15:0] LAST_BYTE    = 16'(FRAME_BYTES - 1);

    state_t      state_q, state_d;
    logic [2:0]  asm_idx_q, asm_idx_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        rand_en_q, rand_en_d;
    logic [15:0] frame_count_d;
    logic        err_d;

    logic        slot_free;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_sop;
    logic        ld_parity;
    logic        ld_asm;
    logic [63:0] asm_shifted;
    logic        at_end;

    // Fibonacci LFSR advanced one byte. The register holds the next eight
    // sequence bits with the oldest in bit 7, so the register itself is the
    // MSB-first randomizer byte.
    function automatic logic [7:0] lfsr_adv8(input logic [7:0] s);
        logic [7:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[6:0], t[7] ^ t[4] ^ t[2] ^ t[0]};
        end
        return t;
    endfunction

    assign slot_free   = !m_axis_valid || m_axis_ready;
    assign asm_shifted = ASM_ALIGNED << {asm_idx_q, 3'b000};
    assign at_end      = (byte_cnt_q == LAST_BYTE);

    always_comb begin
        state_d       = state_q;
        asm_idx_d     = asm_idx_q;
        byte_cnt_d    = byte_cnt_q;
        lfsr_d        = lfsr_q;
        rand_en_d     = rand_en_q;
        frame_count_d = frame_count;
        err_d         = 1'b0;
        s_axis_ready  = 1'b0;
        ld_valid      = 1'b0;
        ld_data       = 8'h00;
        ld_last       = 1'b0;
        ld_sop        = 1'b0;
        ld_parity     = 1'b0;
        ld_asm        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The sop byte stays on the input until the marker has gone
                // out, so ready is withheld for it to keep the handshake honest.
                s_axis_ready = !(s_axis_valid && s_axis_sop);
                if (s_axis_valid) begin
                    if (s_axis_sop) begin
                        rand_en_d = rand_en;
                        lfsr_d    = LFSR_SEED;
                        asm_idx_d = 3'd0;
                        state_d   = ST_ASM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_ASM: begin
                if (slot_free) begin
                    ld_valid = 1'b1;
                    ld_data  = asm_shifted[63:56];
                    ld_asm   = 1'b1;
                    ld_sop   = (asm_idx_q == 3'd0);
                    if (asm_idx_q == ASM_LAST_IDX) begin
                        byte_cnt_d = 16'd0;
                        state_d    = ST_DATA;
                    end else begin
                        asm_idx_d = asm_idx_q + 3'd1;
                    end
                end
            end

            ST_DATA: begin
                s_axis_ready = slot_free;
                if (s_axis_valid && slot_free) begin
                    ld_valid   = 1'b1;
                    ld_data    = s_axis_data ^ (rand_en_q ? lfsr_q : 8'h00);
                    ld_parity  = s_axis_is_parity;
                    lfsr_d     = lfsr_adv8(lfsr_q);
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (s_axis_sop && byte_cnt_q != 16'd0) begin
                        err_d = 1'b1;
                    end
                    // Whichever end condition fires first closes the frame;
                    // disagreement between them is a framing error.
                    if (s_axis_last || at_end) begin
                        ld_last       = 1'b1;
                        frame_count_d = frame_count + 16'd1;
                        state_d       = ST_IDLE;
                        if (s_axis_last != at_end) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rst_n) begin
            s_axis_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            asm_idx_q        <= 3'd0;
            byte_cnt_q       <= 16'd0;
            lfsr_q           <= LFSR_SEED;
            rand_en_q        <= 1'b0;
            frame_count      <= 16'd0;
            frame_err        <= 1'b0;
            m_axis_valid     <= 1'b0;
            m_axis_data      <= 8'h00;
            m_axis_last      <= 1'b0;
            m_axis_sop       <= 1'b0;
            m_axis_is_parity <= 1'b0;
            m_axis_is_asm    <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_idx_q   <= asm_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            lfsr_q      <= lfsr_d;
            rand_en_q   <= rand_en_d;
            frame_count <= frame_count_d;
            frame_err   <= err_d;
            if (slot_free) begin
                m_axis_valid     <= ld_valid;
                m_axis_data      <= ld_data;
                m_axis_last      <= ld_last;
                m_axis_sop       <= ld_sop;
                m_axis_is_parity <= ld_parity;
                m_axis_is_asm    <= ld_asm;
            end
        end
    end

endmodule
